// File: rtl/mem_line_master_if.sv
// rtl/mem_line_master_if.sv - request/prefetch/response handshakes and RAM port A bundle for mem_line_master
interface mem_line_master_if;
  // demand request channel
  logic         req_valid;
  logic         req_ready;
  logic [31:0]  req_addr;
  logic         req_we;
  logic [127:0] req_wdata;
  // prefetch read request channel
  logic         pf_valid;
  logic         pf_ready;
  logic [31:0]  pf_addr;
  // tagged response channel
  logic         resp_valid;
  logic         resp_ready;
  logic [127:0] resp_rdata;
  logic         resp_src;
  logic         resp_err;
  // line RAM port A
  logic [31:0]  addra;
  logic [127:0] dina;
  logic         wea;
  logic [127:0] douta;

  // the line master itself
  modport master (
    input  req_valid, req_addr, req_we, req_wdata,
    input  pf_valid, pf_addr,
    input  resp_ready, douta,
    output req_ready, pf_ready,
    output resp_valid, resp_rdata, resp_src, resp_err,
    output addra, dina, wea
  );

  // requesters, response consumer and RAM around the master
  modport slave (
    output req_valid, req_addr, req_we, req_wdata,
    output pf_valid, pf_addr,
    output resp_ready, douta,
    input  req_ready, pf_ready,
    input  resp_valid, resp_rdata, resp_src, resp_err,
    input  addra, dina, wea
  );
endinterface

// File: rtl/mem_line_master.sv
// rtl/mem_line_master.sv - single-outstanding 128-bit line initiator on RAM port A; prefetch port enabled by MEM_PF_PORT_EN
module mem_line_master #(
  parameter int LATENCY = 4
) (
  input logic               clka,
  input logic               rstn,
  mem_line_master_if.master bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ACCESS,
    S_RESP
  } state_t;

  localparam logic [7:0] CNT_INIT = 8'(LATENCY - 1);

  state_t       r_state;
  logic [7:0]   r_cnt;
  logic         r_req_ready;
  logic [27:0]  r_line;
  logic [127:0] r_dina;
  logic         r_we;
  logic         r_in_range;
  logic         r_wea;
  logic         r_resp_valid;
  logic [127:0] r_rdata;
  logic         r_err;

  logic         w_req_fire;
  logic         w_pf_fire;
  logic [31:0]  w_acc_addr;
  logic         w_acc_in_range;

  assign w_req_fire = bus.req_valid & r_req_ready;

`ifdef MEM_PF_PORT_EN
  logic r_src;

  // demand has strict priority: prefetch is offered only when no demand is pending
  assign bus.pf_ready = r_req_ready & ~bus.req_valid;
  assign w_pf_fire    = bus.pf_valid & bus.pf_ready;
  assign w_acc_addr   = w_req_fire ? bus.req_addr : bus.pf_addr;
  assign bus.resp_src = r_src;

  // source tag is captured with the request and held until the next accept
  always_ff @(posedge clka) begin
    if (!rstn) begin
      r_src <= 1'b0;
    end else if (w_req_fire) begin
      r_src <= 1'b0;
    end else if (w_pf_fire) begin
      r_src <= 1'b1;
    end
  end
`else
  assign bus.pf_ready = 1'b0;
  assign w_pf_fire    = 1'b0;
  assign w_acc_addr   = bus.req_addr;
  assign bus.resp_src = 1'b0;
`endif

  // bit 31 is passed through to the RAM but does not take part in the range test
  assign w_acc_in_range = (w_acc_addr[30:14] == 17'd0);

  assign bus.req_ready  = r_req_ready;
  assign bus.addra      = {r_line, 4'b0000};
  assign bus.dina       = r_dina;
  // reset kills the write strobe immediately so a reset during ACCESS never writes
  assign bus.wea        = r_wea & rstn;
  assign bus.resp_valid = r_resp_valid;
  assign bus.resp_rdata = r_rdata;
  assign bus.resp_err   = r_err;

  // transaction FSM: accept, count down latency, one RAM access cycle, hold response
  always_ff @(posedge clka) begin
    if (!rstn) begin
      r_state      <= S_IDLE;
      r_cnt        <= 8'd0;
      r_req_ready  <= 1'b0;
      r_line       <= 28'd0;
      r_dina       <= 128'd0;
      r_we         <= 1'b0;
      r_in_range   <= 1'b0;
      r_wea        <= 1'b0;
      r_resp_valid <= 1'b0;
      r_rdata      <= 128'd0;
      r_err        <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_req_fire || w_pf_fire) begin
            r_line      <= w_acc_addr[31:4];
            r_dina      <= bus.req_wdata;
            r_we        <= w_req_fire & bus.req_we;
            r_in_range  <= w_acc_in_range;
            r_cnt       <= CNT_INIT;
            r_req_ready <= 1'b0;
            r_state     <= S_WAIT;
          end else begin
            r_req_ready <= 1'b1;
          end
        end
        S_WAIT: begin
          if (r_cnt == 8'd0) begin
            r_wea   <= r_we & r_in_range;
            r_state <= S_ACCESS;
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end
        S_ACCESS: begin
          r_wea        <= 1'b0;
          r_rdata      <= (r_we | ~r_in_range) ? 128'd0 : bus.douta;
          r_err        <= ~r_in_range;
          r_resp_valid <= 1'b1;
          r_state      <= S_RESP;
        end
        S_RESP: begin
          if (bus.resp_ready) begin
            r_resp_valid <= 1'b0;
            r_req_ready  <= 1'b1;
            r_state      <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
